// File: rtl/seq_pattern_tx_pkg.sv
// +--------------------------------------------------------------------------+
// | seq_pkg: shared state encoding for the sequence link, default idle level  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

  localparam logic C_IDLE_BIT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/seq_pattern_tx_if.sv
// +--------------------------------------------------------------------------+
// | seq_pattern_tx_if: request handshake and serial output of the tx block    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface seq_pattern_tx_if #(
  parameter int P_WIDTH = 4,
  parameter int P_CNT_W = 4
);

  logic [P_WIDTH-1:0] i_data;
  logic [P_CNT_W-1:0] i_repeat;
  logic               i_valid;
  logic               o_ready;
  logic               o_x;
  logic               o_x_valid;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_data, i_repeat, i_valid,
    input  o_ready, o_x, o_x_valid, o_busy, o_done
  );

  modport slave (
    input  i_data, i_repeat, i_valid,
    output o_ready, o_x, o_x_valid, o_busy, o_done
  );

endinterface

`default_nettype wire

// File: rtl/seq_pattern_tx_piso.sv
// +--------------------------------------------------------------------------+
// | seq_piso: parallel-in serial-out shift register, load over shift, MSB out |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_piso #(
  parameter int P_WIDTH = 4
) (
  input  wire logic               i_clk,
  input  wire logic               i_reset,
  input  wire logic               i_load,
  input  wire logic               i_shift,
  input  wire logic [P_WIDTH-1:0] i_data,
  output logic                    o_msb
);

  logic [P_WIDTH-1:0] r_sreg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[P_WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_sreg[P_WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// +--------------------------------------------------------------------------+
// | seq_pattern_tx: MSB-first serial pattern transmitter with word repeat;    |
// | SEQ_TX_PARITY_EN adds an even-parity bit after each word. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   P_WIDTH    = 4,
  parameter int   P_CNT_W    = 4,
  parameter logic P_IDLE_BIT = C_IDLE_BIT
) (
  input wire logic         i_clk,
  input wire logic         i_reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int                 C_BC_W = (P_WIDTH > 2) ? $clog2(P_WIDTH) : 1;
  localparam logic [C_BC_W-1:0]  C_LAST = C_BC_W'(P_WIDTH - 1);

  seq_state_e          r_state, w_state_nxt;
  logic [C_BC_W-1:0]   r_bit_cnt, w_bit_nxt;
  logic [P_CNT_W-1:0]  r_rep_cnt, w_rep_nxt;
  logic [P_WIDTH-1:0]  r_hold;
  logic                w_load, w_shift, w_capture, w_msb, w_x;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_rep_cnt <= w_rep_nxt;
      if (w_capture) r_hold <= bus.i_data;
    end
  end

  // Reloads at word boundaries come from the held copy so later i_data changes are invisible.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_valid) begin
          w_load      = 1'b1;
          w_capture   = 1'b1;
          w_rep_nxt   = bus.i_repeat;
          w_bit_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_bit_cnt == C_LAST) begin
`ifdef SEQ_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          if (r_rep_cnt != '0) begin
            w_load    = 1'b1;
            w_rep_nxt = r_rep_cnt - 1'b1;
            w_bit_nxt = '0;
          end else begin
            w_state_nxt = ST_DONE;
          end
`endif
        end else begin
          w_shift   = 1'b1;
          w_bit_nxt = r_bit_cnt + 1'b1;
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PARITY: begin
        if (r_rep_cnt != '0) begin
          w_load      = 1'b1;
          w_rep_nxt   = r_rep_cnt - 1'b1;
          w_bit_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  seq_piso #(
    .P_WIDTH (P_WIDTH)
  ) u_piso (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  ((r_state == ST_IDLE) ? bus.i_data : r_hold),
    .o_msb   (w_msb)
  );

  always_comb begin
    w_x = P_IDLE_BIT;
    case (r_state)
      ST_SHIFT:  w_x = w_msb;
`ifdef SEQ_TX_PARITY_EN
      ST_PARITY: w_x = ^r_hold;
`endif
      default:   w_x = P_IDLE_BIT;
    endcase
  end

  assign bus.o_x       = w_x;
`ifdef SEQ_TX_PARITY_EN
  assign bus.o_x_valid = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
`else
  assign bus.o_x_valid = (r_state == ST_SHIFT);
`endif
  assign bus.o_ready   = (r_state == ST_IDLE);
  assign bus.o_busy    = (r_state != ST_IDLE);
  assign bus.o_done    = (r_state == ST_DONE);

endmodule

`default_nettype wire
